// File: rtl/regbank_writeback.sv
// regbank_writeback: merges ALU and buffered multiplier results onto the register bank write port.
module regbank_writeback #(
  parameter int DEPTH      = 4,
  parameter bit DISCARD_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [4:0]  mul_addr,
  input  logic [31:0] mul_data,
  input  logic [4:0]  query_addr,
  output logic        query_hit,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             push, pop, alu_keep, mul_live;
  always_comb begin
    mul_ready = count != CW'(DEPTH);
    push      = mul_valid && mul_ready;
    pop       = !alu_valid && count != '0;
    alu_keep  = alu_valid && !(DISCARD_R0 && alu_addr == '0);
    mul_live  = !(DISCARD_R0 && mul_addr == '0);
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) query_hit = query_hit | (live[i] && q_addr[i] == query_addr);
    query_hit = (DISCARD_R0 && query_addr == '0) ? 1'b0 : query_hit;
  end
  // live bits are cleared on pop, so live implies occupied; a later push overrides a same-cycle ALU kill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      live    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      wr_en <= alu_valid ? alu_keep : pop && live[head];
      if (alu_valid || pop) begin
        wr_addr <= alu_valid ? alu_addr : q_addr[head];
        wr_data <= alu_valid ? alu_data : q_data[head];
      end
      for (int i = 0; i < DEPTH; i++)
        if (alu_valid && q_addr[i] == alu_addr) live[i] <= 1'b0;
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + AW'(1);
      end
      if (push) begin
        q_addr[tail] <= mul_addr;
        q_data[tail] <= mul_data;
        live[tail]   <= mul_live;
        tail         <= tail + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_regbank_writeback.sv
// tb_regbank_writeback: scoreboard bench; expected bank writes are queued at stimulus time and popped as wr_en fires.
module tb_regbank_writeback;
  logic        clk = 1'b0, reset = 1'b1;
  logic        alu_valid = 1'b0, mul_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mul_addr = '0, query_addr = '0;
  logic [31:0] alu_data = '0, mul_data = '0;
  logic        mul_ready, query_hit, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  int vectors = 0, miscompares = 0;
  regbank_writeback dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_addr(mul_addr), .mul_data(mul_data),
    .query_addr(query_addr), .query_hit(query_hit), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  // advance one edge and retire any bank write against the scoreboard
  task automatic step();
    @(posedge clk);
    #1;
    if (!reset && wr_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          miscompares++;
          $display("FAIL write_order: got addr=%0d data=%h, expected addr=%0d data=%h", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  endtask
  task automatic drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained: %0d writes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b expected 0", wr_en); end
    vectors++; if (wr_addr !== 5'd0) begin miscompares++; $display("FAIL reset_wr_addr got %0d expected 0", wr_addr); end
    vectors++; if (wr_data !== 32'd0) begin miscompares++; $display("FAIL reset_wr_data got %h expected 0", wr_data); end
    vectors++; if (mul_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mul_ready got %b expected 1", mul_ready); end
    vectors++; if (query_hit !== 1'b0) begin miscompares++; $display("FAIL reset_query_hit got %b expected 0", query_hit); end
    reset = 1'b0;
    step();
  endtask
  task automatic test_alu();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_0002;
    exp_q.push_back('{5'd5, 32'h0000_0002});
    step();
    alu_valid = 1'b0;
    step();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL alu_idle wr_en got %b expected 0", wr_en); end
    drained("alu");
  endtask
  task automatic test_mul_drain();
    mul_valid = 1'b1; mul_addr = 5'd3; mul_data = 32'hAAAA_0001; query_addr = 5'd3;
    exp_q.push_back('{5'd3, 32'hAAAA_0001});
    #1;
    vectors++; if (query_hit !== 1'b0) begin miscompares++; $display("FAIL drain_hit_before got %b expected 0", query_hit); end
    step();
    mul_valid = 1'b0;
    #1;
    vectors++; if (query_hit !== 1'b1) begin miscompares++; $display("FAIL drain_hit_buffered got %b expected 1", query_hit); end
    step();
    vectors++; if (query_hit !== 1'b0) begin miscompares++; $display("FAIL drain_hit_after got %b expected 0", query_hit); end
    step();
    drained("mul_drain");
  endtask
  task automatic test_fill();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      mul_valid = 1'b1; mul_addr = 5'(8 + i); mul_data = 32'hB000_0000 + i;
      exp_q.push_back('{5'd1, 32'h0000_0100});
      step();
    end
    vectors++; if (mul_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full got %b expected 0", mul_ready); end
    mul_addr = 5'd12; mul_data = 32'hDEAD_0012;
    exp_q.push_back('{5'd1, 32'h0000_0100});
    step();
    vectors++; if (mul_ready !== 1'b0) begin miscompares++; $display("FAIL fill_still_full got %b expected 0", mul_ready); end
    alu_valid = 1'b0; mul_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{5'(8 + i), 32'hB000_0000 + i});
    step();
    vectors++; if (mul_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_after_pop got %b expected 1", mul_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL fill_consecutive_%0d wr_en got %b expected 1", i, wr_en); end
    end
    step();
    drained("fill");
  endtask
  task automatic test_waw();
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h0000_0055;
    mul_valid = 1'b1; mul_addr = 5'd7; mul_data = 32'h0000_1111; query_addr = 5'd7;
    exp_q.push_back('{5'd2, 32'h0000_0055});
    step();
    mul_valid = 1'b0;
    #1;
    vectors++; if (query_hit !== 1'b1) begin miscompares++; $display("FAIL waw_hit_buffered got %b expected 1", query_hit); end
    alu_addr = 5'd7; alu_data = 32'h0000_2222;
    exp_q.push_back('{5'd7, 32'h0000_2222});
    step();
    vectors++; if (query_hit !== 1'b0) begin miscompares++; $display("FAIL waw_hit_killed got %b expected 0", query_hit); end
    alu_valid = 1'b0;
    step();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL waw_stale_pop wr_en got %b expected 0", wr_en); end
    step();
    drained("waw");
  endtask
  task automatic test_back_to_back();
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h0000_0066;
    mul_valid = 1'b1; mul_addr = 5'd6; mul_data = 32'h0000_0077; query_addr = 5'd6;
    exp_q.push_back('{5'd6, 32'h0000_0066});
    exp_q.push_back('{5'd6, 32'h0000_0077});
    step();
    alu_valid = 1'b0; mul_valid = 1'b0;
    #1;
    vectors++; if (query_hit !== 1'b1) begin miscompares++; $display("FAIL b2b_younger_live got %b expected 1", query_hit); end
    step();
    step();
    drained("b2b");
  endtask
  task automatic test_r0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h0000_0001;
    mul_valid = 1'b1; mul_addr = 5'd0; mul_data = 32'h0000_0005; query_addr = 5'd0;
    step();
    alu_valid = 1'b0; mul_valid = 1'b0;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL r0_alu wr_en got %b expected 0", wr_en); end
    vectors++; if (query_hit !== 1'b0) begin miscompares++; $display("FAIL r0_query got %b expected 0", query_hit); end
    step();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL r0_mul wr_en got %b expected 0", wr_en); end
    step();
    drained("r0");
  endtask
  task automatic test_mid_reset();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0000_0300; query_addr = 5'd20;
    for (int i = 0; i < 3; i++) begin
      mul_valid = 1'b1; mul_addr = 5'(20 + i); mul_data = 32'hC000_0000 + i;
      exp_q.push_back('{5'd1, 32'h0000_0300});
      step();
    end
    mul_valid = 1'b0;
    #1;
    vectors++; if (query_hit !== 1'b1) begin miscompares++; $display("FAIL rst_hit_before got %b expected 1", query_hit); end
    reset = 1'b1; alu_valid = 1'b0;
    #1;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en got %b expected 0", wr_en); end
    vectors++; if (mul_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mul_ready got %b expected 1", mul_ready); end
    vectors++; if (query_hit !== 1'b0) begin miscompares++; $display("FAIL rst_query_hit got %b expected 0", query_hit); end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_release wr_en got %b expected 0", wr_en); end
    drained("mid_reset");
  endtask
  initial begin
    test_reset();
    test_alu();
    test_mul_drain();
    test_fill();
    test_waw();
    test_back_to_back();
    test_r0();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
